// File: rtl/booths_radix4_multiplier_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digit
// select codes and the iteration-count helper.
package booth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    N1   = 3'd3,
    N2   = 3'd4
  } booth_sel_e;

  // Operands are widened by two bits, so WIDTH/2+1 radix-4 digits cover them.
  function automatic int booth_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booths_radix4_multiplier_if.sv
// Start/ready request bus and result bus of the radix-4 Booth multiplier.
interface booths_radix4_multiplier_if #(
  parameter int WIDTH = 8
) ();

  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2*WIDTH-1:0] r_out;
  logic               ready;
  logic               busy;
  logic               done;

  modport master (
    output start, signed_mode, a_in, b_in,
    input  r_out, ready, busy, done
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
    output r_out, ready, busy, done
  );

endinterface

// File: rtl/booths_radix4_multiplier_recoder.sv
// Radix-4 Booth recoder: maps the multiplier triplet {q1,q0,q-1} to a
// signed digit in {-2,-1,0,+1,+2}.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet_i,
  output booth_sel_e sel_o,
  output logic       neg_o,
  output logic       dbl_o
);

  always_comb begin
    sel_o = ZERO;
    case (triplet_i)
      3'b001, 3'b010: sel_o = P1;
      3'b011:         sel_o = P2;
      3'b100:         sel_o = N2;
      3'b101, 3'b110: sel_o = N1;
      default:        sel_o = ZERO;
    endcase
  end

  assign neg_o = (sel_o == N1) || (sel_o == N2);
  assign dbl_o = (sel_o == P2) || (sel_o == N2);

endmodule

// File: rtl/booths_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per clock,
// signed or unsigned operands selected per operation.
module booths_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  booths_radix4_multiplier_if.slave   bus
);

  localparam int XW   = WIDTH + 2;
  localparam int AW   = XW + 2;
  localparam int PW   = 2 * WIDTH;
  localparam int ITER = booth_iter(WIDTH);
  localparam int CW   = $clog2(ITER + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booths_radix4_multiplier: WIDTH must be even and >= 4");
  end

  state_e                state_q, state_d;
  logic signed [XW-1:0]  m_q, m_d;
  logic        [XW-1:0]  q_q, q_d;
  logic                  qm1_q, qm1_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic        [CW-1:0]  cnt_q, cnt_d;
  logic        [PW-1:0]  r_q, r_d;
  logic                  done_q, done_d;

  booth_sel_e            sel;
  logic                  neg, dbl;
  logic signed [XW-1:0]  a_ext, b_ext;
  logic signed [AW-1:0]  m_ext, mag, pp, sum, acc_sh;
  logic        [XW-1:0]  q_sh;

  booth_r4_recoder u_recoder (
    .triplet_i ({q_q[1:0], qm1_q}),
    .sel_o     (sel),
    .neg_o     (neg),
    .dbl_o     (dbl)
  );

  // Two extra bits make unsigned operands non-negative signed values.
  always_comb begin
    a_ext = bus.signed_mode ? {{2{bus.a_in[WIDTH-1]}}, bus.a_in} : {2'b00, bus.a_in};
    b_ext = bus.signed_mode ? {{2{bus.b_in[WIDTH-1]}}, bus.b_in} : {2'b00, bus.b_in};
  end

  // Partial-product add into the guarded upper half, then the 2-bit shift.
  always_comb begin
    m_ext  = {{2{m_q[XW-1]}}, m_q};
    mag    = dbl ? (m_ext <<< 1) : m_ext;
    pp     = (sel == ZERO) ? '0 : (neg ? -mag : mag);
    sum    = acc_q + pp;
    acc_sh = sum >>> 2;
    q_sh   = {sum[1:0], q_q[XW-1:2]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = a_ext;
          q_d     = b_ext;
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          r_d     = {acc_sh[PW-XW-1:0], q_sh};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign bus.r_out = r_q;
  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == CALC);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_booths_radix4_multiplier.sv
// Bench for the radix-4 Booth multiplier: WIDTH=8 directed vectors with a
// cycle-level reference model, plus WIDTH=16 and WIDTH=4 random products.
module tb_booths_radix4_multiplier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  booths_radix4_multiplier_if #(.WIDTH(8))  bus8  ();
  booths_radix4_multiplier_if #(.WIDTH(16)) bus16 ();
  booths_radix4_multiplier_if #(.WIDTH(4))  bus4  ();

  booths_radix4_multiplier #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));
  booths_radix4_multiplier #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
  booths_radix4_multiplier #(.WIDTH(4))  u_dut4  (.clk(clk), .reset(reset), .bus(bus4));

  function automatic longint ref_mul(input int w, input bit sm, input longint a, input longint b);
    longint av, bv, mask;
    mask = (longint'(1) << w) - 1;
    av = a & mask;
    bv = b & mask;
    if (sm && av[w-1]) av = av - (longint'(1) << w);
    if (sm && bv[w-1]) bv = bv - (longint'(1) << w);
    return (av * bv) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic check_eq(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model of the WIDTH=8 instance: a busy flag and a countdown.
  bit     m_busy;
  int     m_cnt;
  longint m_prod;
  longint exp_r;
  bit     exp_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy   = 1'b0;
      m_cnt    = 0;
      exp_r    = 0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy   = 1'b0;
          exp_r    = m_prod;
          exp_done = 1'b1;
        end
      end else if (bus8.start) begin
        m_busy = 1'b1;
        m_cnt  = 5;
        m_prod = ref_mul(8, bus8.signed_mode, longint'(bus8.a_in), longint'(bus8.b_in));
      end
    end
  end

  always @(negedge clk) begin
    check_eq("cmp_r_out", longint'(bus8.r_out), exp_r);
    check_eq("cmp_done",  longint'(bus8.done),  longint'(exp_done));
    check_eq("cmp_ready", longint'(bus8.ready), longint'(!m_busy));
    check_eq("cmp_busy",  longint'(bus8.busy),  longint'(m_busy));
  end

  // Issue one WIDTH=8 operation from #1 after an edge; returns in the done cycle.
  task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] expv, input string nm);
    int cyc, lowcnt;
    bus8.start       = 1'b1;
    bus8.signed_mode = sm;
    bus8.a_in        = a;
    bus8.b_in        = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc    = 0;
    lowcnt = 0;
    while (!bus8.done && cyc < 20) begin
      if (!bus8.ready) lowcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({nm, "_latency"},   longint'(cyc),       5);
    check_eq({nm, "_ready_low"}, longint'(lowcnt),    5);
    check_eq({nm, "_r_out"},     longint'(bus8.r_out), longint'(expv));
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.a_in  = '0; bus8.b_in  = '0;
    bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.a_in = '0; bus16.b_in = '0;
    bus4.start  = 1'b0; bus4.signed_mode  = 1'b0; bus4.a_in  = '0; bus4.b_in  = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_r_out", longint'(bus8.r_out), 0);
    check_eq("rst_ready", longint'(bus8.ready), 1);
    check_eq("rst_busy",  longint'(bus8.busy),  0);
    check_eq("rst_done",  longint'(bus8.done),  0);
    @(posedge clk); #1 reset = 1'b0;

    op8(1'b1, 8'h03, 8'h04, 16'h000C, "s_03x04");
    op8(1'b1, 8'hFD, 8'h04, 16'hFFF4, "s_FDx04");
    op8(1'b0, 8'hFD, 8'h04, 16'h03F4, "u_FDx04");
    op8(1'b1, 8'hFD, 8'hFC, 16'h000C, "s_FDxFC");
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "s_80x80");
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_FFxFF");
    op8(1'b1, 8'h7F, 8'h80, 16'hC080, "s_7Fx80");
    // Second start lands in the done cycle of the first.
    op8(1'b0, 8'h03, 8'h04, 16'h000C, "b2b_first");
    op8(1'b0, 8'h34, 8'h04, 16'h00D0, "b2b_second");

    // Start pulsed mid-operation with different operands must be ignored.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.signed_mode = 1'b1; bus8.a_in = 8'h05; bus8.b_in = 8'h06;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.signed_mode = 1'b0; bus8.a_in = 8'h7F; bus8.b_in = 8'h7F;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a_in = 8'h00; bus8.b_in = 8'h00;
    cyc = 3;
    while (!bus8.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("ignore_latency", longint'(cyc), 5);
    check_eq("ignore_r_out",   longint'(bus8.r_out), 16'h001E);
    @(posedge clk); #1;
    check_eq("ignore_idle_after", longint'(bus8.ready), 1);

    // Asynchronous reset two cycles into an operation.
    bus8.start = 1'b1; bus8.signed_mode = 1'b1; bus8.a_in = 8'h11; bus8.b_in = 8'h22;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_r_out", longint'(bus8.r_out), 0);
    check_eq("abort_ready", longint'(bus8.ready), 1);
    check_eq("abort_busy",  longint'(bus8.busy),  0);
    check_eq("abort_done",  longint'(bus8.done),  0);
    @(posedge clk); #1 reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus8.done) saw_done = 1'b1;
    end
    check_eq("abort_no_done", longint'(saw_done), 0);
    op8(1'b1, 8'h11, 8'h22, 16'h0242, "after_abort");

    fork
      begin
        int c16;
        longint e16;
        for (int i = 0; i < 1000; i++) begin
          @(posedge clk); #1;
          bus16.signed_mode = 1'($urandom);
          bus16.a_in        = 16'($urandom);
          bus16.b_in        = 16'($urandom);
          bus16.start       = 1'b1;
          e16 = ref_mul(16, bus16.signed_mode, longint'(bus16.a_in), longint'(bus16.b_in));
          @(posedge clk); #1;
          bus16.start = 1'b0;
          c16 = 0;
          while (!bus16.done && c16 < 30) begin
            @(posedge clk); #1;
            c16++;
          end
          check_eq("w16_latency", longint'(c16), 9);
          check_eq("w16_r_out",   longint'(bus16.r_out), e16);
        end
      end
      begin
        int c4;
        longint e4;
        for (int i = 0; i < 1000; i++) begin
          @(posedge clk); #1;
          bus4.signed_mode = 1'($urandom);
          bus4.a_in        = 4'($urandom);
          bus4.b_in        = 4'($urandom);
          bus4.start       = 1'b1;
          e4 = ref_mul(4, bus4.signed_mode, longint'(bus4.a_in), longint'(bus4.b_in));
          @(posedge clk); #1;
          bus4.start = 1'b0;
          c4 = 0;
          while (!bus4.done && c4 < 30) begin
            @(posedge clk); #1;
            c4++;
          end
          check_eq("w4_latency", longint'(c4), 3);
          check_eq("w4_r_out",   longint'(bus4.r_out), e4);
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
